gcm_stream_feeder: RTL and testbench

Host-side transmitter for the AES-GCM datapath's AAD and payload streams. It takes a 32-bit host word stream, packs it into 128-bit beats, and presents them in GCM order: all AAD first, then all payload. For each beat it generates byte-keep masks and last flags from the configured bit lengths. It sits between the host FIFO and the datapath's aad_*/din_* ports and is started by the same start pulse as the datapath.

---
 rtl/gcm_pkg.sv | 35 +++
 rtl/gcm_word_packer.sv | 54 +++++
 rtl/gcm_stream_feeder.sv | 165 ++++++++++++++++
 tb/tb_gcm_stream_feeder.sv | 273 +++++++++++++++++++++++++++
 4 files changed

// File: rtl/gcm_pkg.sv
// Shared state encoding, stream widths and keep/mask helpers for the GCM stream feeder.
package gcm_pkg;

    localparam int GCM_BEAT_W = 128;
    localparam int GCM_KEEP_W = 16;
    localparam int HOST_W     = 32;

    typedef enum logic [2:0] {
        IDLE     = 3'd0,
        AAD_FILL = 3'd1,
        AAD_SEND = 3'd2,
        PLD_FILL = 3'd3,
        PLD_SEND = 3'd4,
        DONE     = 3'd5
    } gcm_state_e;

    function automatic logic [GCM_KEEP_W-1:0] keep_from_count(input logic [4:0] nb);
        logic [GCM_KEEP_W-1:0] k;
        k = {GCM_KEEP_W{1'b0}};
        for (int i = 0; i < GCM_KEEP_W; i++) begin
            k[i] = (5'(i) < nb);
        end
        return k;
    endfunction

    function automatic logic [GCM_BEAT_W-1:0] keep_to_mask(input logic [GCM_KEEP_W-1:0] keep);
        logic [GCM_BEAT_W-1:0] m;
        m = {GCM_BEAT_W{1'b0}};
        for (int i = 0; i < GCM_KEEP_W; i++) begin
            m[8*i +: 8] = {8{keep[i]}};
        end
        return m;
    endfunction

endpackage

// File: rtl/gcm_word_packer.sv
// 32-to-128 word accumulator with word index and clear.
// GCM_FEEDER_BYTESWAP_EN byte-reverses each host word before packing.
module gcm_word_packer
    import gcm_pkg::*;
(
    input  logic                  clk,
    input  logic                  rst_n,
    input  logic                  clr,
    input  logic                  wr_en,
    input  logic [HOST_W-1:0]     wdata,
    output logic [GCM_BEAT_W-1:0] beat,
    output logic [1:0]            widx
);

    logic [GCM_BEAT_W-1:0] beat_q, beat_d;
    logic [1:0]            widx_q, widx_d;
    logic [HOST_W-1:0]     word_s;

`ifdef GCM_FEEDER_BYTESWAP_EN
    assign word_s = {wdata[7:0], wdata[15:8], wdata[23:16], wdata[31:24]};
`else
    assign word_s = wdata;
`endif

    // Next beat contents: clear wins over a word write
    always_comb begin
        beat_d = beat_q;
        widx_d = widx_q;
        if (clr) begin
            beat_d = {GCM_BEAT_W{1'b0}};
            widx_d = 2'd0;
        end else if (wr_en) begin
            beat_d[{widx_q, 5'd0} +: HOST_W] = word_s;
            widx_d = widx_q + 2'd1;
        end else begin
            beat_d = beat_q;
        end
    end

    // Beat and index registers
    always_ff @(posedge clk or negedge rst_n) begin
        if (!rst_n) begin
            beat_q <= {GCM_BEAT_W{1'b0}};
            widx_q <= 2'd0;
        end else begin
            beat_q <= beat_d;
            widx_q <= widx_d;
        end
    end

    assign beat = beat_q;
    assign widx = widx_q;

endmodule

// File: rtl/gcm_stream_feeder.sv
// Packs host words into GCM-ordered AAD then payload beats with keep/last.
// Optional host byte reversal via GCM_FEEDER_BYTESWAP_EN (in gcm_word_packer).
module gcm_stream_feeder
    import gcm_pkg::*;
(
    input  logic                  clk,
    input  logic                  rst_n,
    input  logic                  start,
    input  logic [63:0]           len_aad_bits,
    input  logic [63:0]           len_pld_bits,
    input  logic                  s_valid,
    output logic                  s_ready,
    input  logic [HOST_W-1:0]     s_data,
    output logic                  aad_valid,
    input  logic                  aad_ready,
    output logic                  aad_last,
    output logic [GCM_BEAT_W-1:0] aad_data,
    output logic [GCM_KEEP_W-1:0] aad_keep,
    output logic                  din_valid,
    input  logic                  din_ready,
    output logic                  din_last,
    output logic [GCM_BEAT_W-1:0] din_data,
    output logic [GCM_KEEP_W-1:0] din_keep,
    output logic                  busy,
    output logic                  done,
    output logic                  err
);

    gcm_state_e            state_q, state_d;
    logic [60:0]           aad_rem_q, aad_rem_d, pld_rem_q, pld_rem_d;
    logic                  err_q, err_d;
    logic                  start_d_q;
    logic                  start_edge_s, pk_clr_s, pk_wr_s, in_aad_s, last_word_s, last_s;
    logic [60:0]           cur_rem_s;
    logic [4:0]            nb_s, bytes_after_s;
    logic [GCM_KEEP_W-1:0] keep_s;
    logic [GCM_BEAT_W-1:0] beat_s, beat_masked_s;
    logic [1:0]            widx_s;

    gcm_word_packer u_packer (
        .clk   (clk),
        .rst_n (rst_n),
        .clr   (pk_clr_s),
        .wr_en (pk_wr_s),
        .wdata (s_data),
        .beat  (beat_s),
        .widx  (widx_s)
    );

    // Current-beat geometry derived from the active section's remaining bytes
    always_comb begin
        start_edge_s  = start & ~start_d_q;
        in_aad_s      = (state_q == AAD_FILL) || (state_q == AAD_SEND);
        cur_rem_s     = in_aad_s ? aad_rem_q : pld_rem_q;
        nb_s          = (cur_rem_s >= 61'd16) ? 5'd16 : cur_rem_s[4:0];
        bytes_after_s = {1'b0, widx_s, 2'b00} + 5'd4;
        last_word_s   = (bytes_after_s >= nb_s);
        last_s        = (cur_rem_s == {56'd0, nb_s});
        keep_s        = keep_from_count(nb_s);
        beat_masked_s = beat_s & keep_to_mask(keep_s);
    end

    // Next-state, counters and handshake decode
    always_comb begin
        state_d   = state_q;
        aad_rem_d = aad_rem_q;
        pld_rem_d = pld_rem_q;
        err_d     = err_q;
        pk_clr_s  = 1'b0;
        pk_wr_s   = 1'b0;
        case (state_q)
            IDLE, DONE: begin
                if (start_edge_s) begin
                    aad_rem_d = len_aad_bits[63:3];
                    pld_rem_d = len_pld_bits[63:3];
                    err_d     = 1'b0;
                    pk_clr_s  = 1'b1;
                    if ((len_aad_bits[2:0] != 3'd0) || (len_pld_bits[2:0] != 3'd0)) begin
                        err_d   = 1'b1;
                        state_d = IDLE;
                    end else if (len_aad_bits[63:3] != 61'd0) begin
                        state_d = AAD_FILL;
                    end else if (len_pld_bits[63:3] != 61'd0) begin
                        state_d = PLD_FILL;
                    end else begin
                        state_d = DONE;
                    end
                end else begin
                    state_d = IDLE;
                end
            end
            AAD_FILL, PLD_FILL: begin
                if (s_valid) begin
                    pk_wr_s = 1'b1;
                    if (last_word_s) begin
                        state_d = (state_q == AAD_FILL) ? AAD_SEND : PLD_SEND;
                    end else begin
                        state_d = state_q;
                    end
                end else begin
                    state_d = state_q;
                end
            end
            AAD_SEND: begin
                if (aad_ready) begin
                    pk_clr_s  = 1'b1;
                    aad_rem_d = aad_rem_q - {56'd0, nb_s};
                    if (!last_s) begin
                        state_d = AAD_FILL;
                    end else if (pld_rem_q != 61'd0) begin
                        state_d = PLD_FILL;
                    end else begin
                        state_d = DONE;
                    end
                end else begin
                    state_d = AAD_SEND;
                end
            end
            PLD_SEND: begin
                if (din_ready) begin
                    pk_clr_s  = 1'b1;
                    pld_rem_d = pld_rem_q - {56'd0, nb_s};
                    state_d   = last_s ? DONE : PLD_FILL;
                end else begin
                    state_d = PLD_SEND;
                end
            end
            default: begin
                state_d = IDLE;
            end
        endcase
    end

    // State, counters, error flag and start-edge history
    always_ff @(posedge clk or negedge rst_n) begin
        if (!rst_n) begin
            state_q   <= IDLE;
            aad_rem_q <= 61'd0;
            pld_rem_q <= 61'd0;
            err_q     <= 1'b0;
            start_d_q <= 1'b0;
        end else begin
            state_q   <= state_d;
            aad_rem_q <= aad_rem_d;
            pld_rem_q <= pld_rem_d;
            err_q     <= err_d;
            start_d_q <= start;
        end
    end

    // Outputs decode from registered state only, so valid never depends on ready
    assign s_ready   = (state_q == AAD_FILL) || (state_q == PLD_FILL);
    assign aad_valid = (state_q == AAD_SEND);
    assign din_valid = (state_q == PLD_SEND);
    assign aad_last  = aad_valid & last_s;
    assign din_last  = din_valid & last_s;
    assign aad_keep  = aad_valid ? keep_s : {GCM_KEEP_W{1'b0}};
    assign din_keep  = din_valid ? keep_s : {GCM_KEEP_W{1'b0}};
    assign aad_data  = aad_valid ? beat_masked_s : {GCM_BEAT_W{1'b0}};
    assign din_data  = din_valid ? beat_masked_s : {GCM_BEAT_W{1'b0}};
    assign busy      = s_ready | aad_valid | din_valid;
    assign done      = (state_q == DONE);
    assign err       = err_q;

endmodule

// File: tb/tb_gcm_stream_feeder.sv
// Randomized bench for gcm_stream_feeder against a byte-stream reference model.
// Build with or without GCM_FEEDER_BYTESWAP_EN; the model follows the same macro.
module tb_gcm_stream_feeder;

    logic         clk = 1'b0, rst_n = 1'b0, start = 1'b0;
    logic [63:0]  len_aad_bits = 64'd0, len_pld_bits = 64'd0;
    logic         s_valid = 1'b0, aad_ready = 1'b0, din_ready = 1'b0;
    logic [31:0]  s_data = 32'd0;
    logic         s_ready, aad_valid, aad_last, din_valid, din_last, busy, done, err;
    logic [127:0] aad_data, din_data;
    logic [15:0]  aad_keep, din_keep;

    gcm_stream_feeder dut (
        .clk(clk), .rst_n(rst_n), .start(start),
        .len_aad_bits(len_aad_bits), .len_pld_bits(len_pld_bits),
        .s_valid(s_valid), .s_ready(s_ready), .s_data(s_data),
        .aad_valid(aad_valid), .aad_ready(aad_ready), .aad_last(aad_last),
        .aad_data(aad_data), .aad_keep(aad_keep),
        .din_valid(din_valid), .din_ready(din_ready), .din_last(din_last),
        .din_data(din_data), .din_keep(din_keep),
        .busy(busy), .done(done), .err(err)
    );

    always #5 clk = ~clk;

    typedef struct {
        bit           is_aad;
        logic [127:0] data;
        logic [15:0]  keep;
        bit           last;
        int           words;
    } beat_t;

    beat_t       expq[$];
    logic [31:0] hostq[$];
    int  vectors = 0, miscompares = 0;
    bit  busy_m = 0, err_m = 0, done_next = 0, start_prev_m = 0, ev_m = 0;
    bit  start_req = 0, rdy_hold = 0, seq_mode = 0;
    int  words_in_beat = 0, word_ctr = 0, cyc = 0, start_cyc = 0, done_cyc = 0;
    int  vprob = 100, rprob = 100, lat;

    task automatic cmp(input string nm, input logic [127:0] act, input logic [127:0] expv);
        vectors++;
        if (act !== expv) begin
            miscompares++;
            $display("FAIL %s @cyc %0d: got %h expected %h", nm, cyc, act, expv);
        end
    endtask

    // Section bytes come from host words in order; each 16-byte slice is one beat
    task automatic add_section(input bit is_aad, input int nbytes);
        logic [31:0] w[$];
        logic [31:0] wd;
        int nw;
        nw = (nbytes + 3) / 4;
        for (int i = 0; i < nw; i++) begin
            if (seq_mode) wd = {8'(4*word_ctr), 8'(4*word_ctr+1), 8'(4*word_ctr+2), 8'(4*word_ctr+3)};
            else          wd = $urandom();
            word_ctr++;
            w.push_back(wd);
            hostq.push_back(wd);
        end
        for (int b = 0; b * 16 < nbytes; b++) begin
            beat_t e;
            int nb, j, sh;
            nb = (nbytes - 16*b > 16) ? 16 : nbytes - 16*b;
            e.is_aad = is_aad; e.data = 128'd0; e.keep = 16'd0;
            for (int i = 0; i < nb; i++) begin
                j = 16*b + i;
`ifdef GCM_FEEDER_BYTESWAP_EN
                sh = 3 - (j % 4);
`else
                sh = j % 4;
`endif
                e.data[8*i +: 8] = 8'(w[j/4] >> (8*sh));
                e.keep[i] = 1'b1;
            end
            e.last  = (16*b + nb == nbytes);
            e.words = (nb + 3) / 4;
            expq.push_back(e);
        end
    endtask

    task automatic model_start();
        err_m = 0; expq.delete(); hostq.delete();
        words_in_beat = 0; word_ctr = 0; start_cyc = cyc;
        if (len_aad_bits[2:0] != 3'd0 || len_pld_bits[2:0] != 3'd0) begin
            err_m = 1;
        end else begin
            add_section(1'b1, int'(len_aad_bits >> 3));
            add_section(1'b0, int'(len_pld_bits >> 3));
            if (expq.size() == 0) done_next = 1;
            else                  busy_m = 1;
        end
    endtask

    // Compare all outputs against the model; called once per cycle, #1 after the edge
    task automatic check();
        bit exp_done;
        exp_done = done_next; done_next = 0;
        ev_m = 0;
        if (busy_m && expq.size() > 0) ev_m = (words_in_beat == expq[0].words);
        if (done) done_cyc = cyc;
        cmp("busy", busy, busy_m);
        cmp("done", done, exp_done);
        cmp("err", err, err_m);
        cmp("s_ready", s_ready, busy_m && !ev_m);
        cmp("aad_valid", aad_valid, ev_m && expq[0].is_aad);
        cmp("din_valid", din_valid, ev_m && !expq[0].is_aad);
        if (ev_m) begin
            if (expq[0].is_aad) begin
                cmp("aad_data", aad_data, expq[0].data);
                cmp("aad_keep", aad_keep, expq[0].keep);
                cmp("aad_last", aad_last, expq[0].last);
            end else begin
                cmp("din_data", din_data, expq[0].data);
                cmp("din_keep", din_keep, expq[0].keep);
                cmp("din_last", din_last, expq[0].last);
            end
        end
    endtask

    task automatic drive();
        bit busy_pre, hs;
        busy_pre = busy_m;
        start = start_req;
        s_valid = (hostq.size() > 0) && ($urandom_range(99) < vprob);
        if (s_valid) s_data = hostq[0];
        else         s_data = $urandom();
        aad_ready = !rdy_hold && ($urandom_range(99) < rprob);
        din_ready = !rdy_hold && ($urandom_range(99) < rprob);
        if (s_valid && busy_m && !ev_m) begin
            void'(hostq.pop_front());
            words_in_beat++;
        end
        if (ev_m) begin
            hs = expq[0].is_aad ? aad_ready : din_ready;
            if (hs) begin
                void'(expq.pop_front());
                words_in_beat = 0;
                if (expq.size() == 0) begin busy_m = 0; done_next = 1; end
            end
        end
        if (start && !start_prev_m && !busy_pre) model_start();
        start_prev_m = start;
    endtask

    task automatic cycle();
        check();
        drive();
        @(posedge clk); #1;
        cyc++;
    endtask

    task automatic start_op(input longint unsigned ab, input longint unsigned pb);
        len_aad_bits = ab; len_pld_bits = pb;
        start_req = 1; cycle(); start_req = 0;
    endtask

    task automatic wait_done(output int latency);
        int n;
        n = 0;
        while ((busy_m || done_next) && n < 3000) begin cycle(); n++; end
        if (busy_m || done_next) begin
            vectors++; miscompares++;
            $display("FAIL timeout: busy still %0d after %0d cycles, required 0", busy, n);
            busy_m = 0; done_next = 0;
        end
        latency = done_cyc - start_cyc;
        cycle(); cycle();
    endtask

    task automatic check_reset_outputs();
        cmp("rst_busy", busy, 1'b0);       cmp("rst_done", done, 1'b0);
        cmp("rst_err", err, 1'b0);         cmp("rst_s_ready", s_ready, 1'b0);
        cmp("rst_aad_valid", aad_valid, 1'b0); cmp("rst_din_valid", din_valid, 1'b0);
        cmp("rst_aad_data", aad_data, 128'd0); cmp("rst_din_data", din_data, 128'd0);
        cmp("rst_keep", {aad_keep, din_keep}, 32'd0);
        cmp("rst_last", {aad_last, din_last}, 2'd0);
    endtask

    initial begin
        int n;
        #1;
        check_reset_outputs();
        #22 rst_n = 1'b1;
        @(posedge clk); #1;
        cycle(); cycle();

        // Full AAD beat then two payload beats, contiguous words, ready held high
        seq_mode = 1; vprob = 100; rprob = 100;
        start_op(64'd128, 64'd256);
        cmp("pin_nbeats", 32'(expq.size()), 32'd3);
`ifdef GCM_FEEDER_BYTESWAP_EN
        cmp("pin_aad0", expq[0].data, 128'h0f0e0d0c_0b0a0908_07060504_03020100);
`else
        cmp("pin_aad0", expq[0].data, 128'h0c0d0e0f_08090a0b_04050607_00010203);
`endif
        cmp("pin_lasts", {expq[0].last, expq[1].last, expq[2].last}, 3'b101);
        wait_done(lat);
        cmp("latency_full", 32'(lat), 32'd16);

        // 5-byte AAD only
        start_op(64'd40, 64'd0);
        cmp("pin_keep5", expq[0].keep, 16'h001F);
`ifdef GCM_FEEDER_BYTESWAP_EN
        cmp("pin_aad5", expq[0].data, {88'd0, 8'h04, 32'h03020100});
`else
        cmp("pin_aad5", expq[0].data, {88'd0, 8'h07, 32'h00010203});
`endif
        wait_done(lat);
        cmp("latency_5B", 32'(lat), 32'd4);

        // 17-byte payload only
        start_op(64'd0, 64'd136);
        cmp("pin_keep17", {expq[0].keep, expq[1].keep}, 32'hFFFF_0001);
        wait_done(lat);

        // Length error, then a clean start clears it; then both zero
        start_op(64'd0, 64'd12);
        wait_done(lat);
        cycle();
        start_op(64'd0, 64'd8);
        wait_done(lat);
        start_op(64'd0, 64'd0);
        wait_done(lat);
        cmp("latency_zero", 32'(lat), 32'd1);

        // AAD stall with a second start edge while busy
        seq_mode = 0;
        rdy_hold = 1;
        start_op(64'd128, 64'd128);
        for (int i = 0; i < 14; i++) begin
            start_req = (i == 6);
            cycle();
        end
        start_req = 0; rdy_hold = 0;
        wait_done(lat);

        // Asynchronous reset in the middle of payload packing
        start_op(64'd32, 64'd64);
        n = 0;
        while (!(busy_m && expq.size() > 0 && !expq[0].is_aad && words_in_beat > 0) && n < 200) begin
            cycle(); n++;
        end
        cmp("reached_pld_fill", 32'(n < 200), 32'd1);
        #2 rst_n = 1'b0;
        #1 check_reset_outputs();
        busy_m = 0; err_m = 0; done_next = 0; start_prev_m = 0;
        expq.delete(); hostq.delete(); words_in_beat = 0;
        start = 0; s_valid = 0; aad_ready = 0; din_ready = 0;
        @(posedge clk); #3 rst_n = 1'b1;
        @(posedge clk); #1;
        start_op(64'd48, 64'd32);
        wait_done(lat);

        // Randomized operations with random flow control
        for (int k = 0; k < 30; k++) begin
            longint unsigned ab, pb;
            ab = 64'($urandom_range(40)) * 8;
            pb = 64'($urandom_range(40)) * 8;
            if ($urandom_range(9) == 0) pb = pb | 64'($urandom_range(7, 1));
            vprob = $urandom_range(100, 40);
            rprob = $urandom_range(100, 30);
            start_op(ab, pb);
            wait_done(lat);
        end

        $display("== %0d vectors applied, %0d miscompares ==", vectors, miscompares);
        $finish;
    end

endmodule
